fp_addsub_seq: RTL and testbench

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

---
 rtl/fp_addsub_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor: a six-state FSM walks one operation through
// unpack, align, add, normalise and round, with flush-to-zero for denormal inputs and results.
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [1:0]   i_sel,
   input  logic [1:0]   i_round,
   input  logic         i_start,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_error,
   output logic         o_overflow,
   output logic [W-1:0] o_y
);

   localparam int EXT_W = MAN_W + 4;
   localparam int SUM_W = EXT_W + 1;
   localparam int LZ_W  = $clog2(SUM_W + 1);
   localparam int XE_W  = EXP_W + 2;
   localparam logic [EXP_W-1:0]       EXP_ONES = '1;
   localparam logic [EXP_W-1:0]       EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic signed [XE_W-1:0] ONE_X    = XE_W'(1);
   localparam logic [W-1:0]           QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

   function automatic logic [LZ_W-1:0] f_clz(input logic [EXT_W-1:0] v);
      logic [LZ_W-1:0] n;
      logic            found;
      n     = '0;
      found = 1'b0;
      for (int i = EXT_W - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + LZ_W'(1);
         end
      end
      return n;
   endfunction

   function automatic logic f_round_inc(input logic [1:0] mode, input logic sgn,
                                        input logic lsb, input logic g, input logic r,
                                        input logic s);
      case (mode)
         2'b00:   return g & (r | s | lsb);
         2'b01:   return 1'b0;
         2'b10:   return ~sgn & (g | r | s);
         default: return sgn & (g | r | s);
      endcase
   endfunction

   function automatic logic [W-1:0] f_ovf_res(input logic [1:0] mode, input logic sgn);
      logic [W-1:0] inf_v;
      logic [W-1:0] max_v;
      inf_v = {sgn, EXP_ONES, {MAN_W{1'b0}}};
      max_v = {sgn, EXP_MAXF, {MAN_W{1'b1}}};
      case (mode)
         2'b00:   return inf_v;
         2'b01:   return max_v;
         2'b10:   return sgn ? max_v : inf_v;
         default: return sgn ? inf_v : max_v;
      endcase
   endfunction

   state_t                   r_state, w_next;
   logic                     w_accept;
   logic [W-1:0]             r_a, r_b;
   logic [1:0]               r_sel, r_rnd;
   logic                     r_sgn_big, r_eff_sub, r_err, r_inf, r_inf_sgn;
   logic signed [XE_W-1:0]   r_exp, r_nexp;
   logic [MAN_W:0]           r_sig_big, r_sig_sml;
   logic [EXP_W-1:0]         r_shift;
   logic [EXT_W-1:0]         r_aln, r_norm;
   logic [SUM_W-1:0]         r_sum;
   logic                     r_done, r_error, r_ovf;
   logic [W-1:0]             r_y;

   // FSM: state register, next state, outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_UNPACK;
         S_UNPACK: w_next = S_ALIGN;
         S_ALIGN:  w_next = S_ADD;
         S_ADD:    w_next = S_NORM;
         S_NORM:   w_next = S_ROUND;
         default:  w_next = S_IDLE;
      endcase
   end

   // The done cycle is spent in IDLE, so a start coinciding with done is refused here.
   always_comb begin
      o_busy   = (r_state != S_IDLE);
      w_accept = (r_state == S_IDLE) && i_start && !r_done;
   end

   // Unpack: classify operands and order them by magnitude (exponent 0 counts as zero)
   logic             w_sa, w_sb, w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic [W-2:0]     w_ka, w_kb;
   logic [MAN_W:0]   w_siga, w_sigb;

   assign w_sa     = r_a[W-1];
   assign w_sb     = r_b[W-1] ^ r_sel[0];
   assign w_ea     = r_a[W-2:MAN_W];
   assign w_eb     = r_b[W-2:MAN_W];
   assign w_fa     = r_a[MAN_W-1:0];
   assign w_fb     = r_b[MAN_W-1:0];
   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);
   assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
   assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
   assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
   assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
   assign w_ka     = w_a_zero ? '0 : r_a[W-2:0];
   assign w_kb     = w_b_zero ? '0 : r_b[W-2:0];
   assign w_swap   = (w_kb > w_ka);
   assign w_siga   = w_a_zero ? '0 : {1'b1, w_fa};
   assign w_sigb   = w_b_zero ? '0 : {1'b1, w_fb};

   // Align: shift the smaller significand right, folding every lost bit into sticky
   logic [EXT_W-1:0] w_ext_sml, w_aln;
   logic             w_lost;
   assign w_ext_sml = {r_sig_sml, 3'b000};
   assign w_lost    = |(w_ext_sml & ~({EXT_W{1'b1}} << r_shift));
   assign w_aln     = (w_ext_sml >> r_shift) | {{(EXT_W-1){1'b0}}, w_lost};

   // Add: big magnitude minus smaller never goes negative
   logic [SUM_W-1:0] w_big_ext, w_sum;
   assign w_big_ext = {1'b0, r_sig_big, 3'b000};
   assign w_sum     = r_eff_sub ? (w_big_ext - {1'b0, r_aln}) : (w_big_ext + {1'b0, r_aln});

   // Normalise: carry-out right shift or cancellation left shift
   logic [LZ_W-1:0]        w_lz;
   logic [EXT_W-1:0]       w_norm;
   logic signed [XE_W-1:0] w_nexp;
   assign w_lz = f_clz(r_sum[EXT_W-1:0]);
   always_comb begin
      w_norm = r_sum[EXT_W-1:0] << w_lz;
      w_nexp = r_exp - $signed({{(XE_W-LZ_W){1'b0}}, w_lz});
      if (r_sum[SUM_W-1]) begin
         w_norm = {r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
         w_nexp = r_exp + ONE_X;
      end
   end

   // Round and assemble; a zero hidden bit after normalising means an exact zero sum
   logic                   w_inc, w_uf, w_of;
   logic [MAN_W:0]         w_frac;
   logic signed [XE_W-1:0] w_rexp;
   logic [W-1:0]           w_res;
   assign w_inc  = f_round_inc(r_rnd, r_sgn_big, r_norm[3], r_norm[2], r_norm[1], r_norm[0]);
   assign w_frac = {1'b0, r_norm[EXT_W-2:3]} + {{MAN_W{1'b0}}, w_inc};
   assign w_rexp = r_nexp + $signed({{(XE_W-1){1'b0}}, w_frac[MAN_W]});
   assign w_uf   = (r_nexp < ONE_X);
   assign w_of   = (w_rexp >= $signed({2'b00, EXP_ONES}));

   always_comb begin
      w_res = {r_sgn_big, w_rexp[EXP_W-1:0], w_frac[MAN_W-1:0]};
      if (r_err)                   w_res = QNAN;
      else if (r_inf)              w_res = {r_inf_sgn, EXP_ONES, {MAN_W{1'b0}}};
      else if (!r_norm[EXT_W-1])   w_res = {(r_eff_sub ? (r_rnd == 2'b11) : r_sgn_big), {(W-1){1'b0}}};
      else if (w_uf)               w_res = {r_sgn_big, {(W-1){1'b0}}};
      else if (w_of)               w_res = f_ovf_res(r_rnd, r_sgn_big);
   end

   always_ff @(posedge i_clk) begin
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               r_a   <= i_a;
               r_b   <= i_b;
               r_sel <= i_sel;
               r_rnd <= i_round;
            end
         end
         S_UNPACK: begin
            r_sgn_big <= w_swap ? w_sb : w_sa;
            r_eff_sub <= w_sa ^ w_sb;
            r_exp     <= $signed({2'b00, (w_swap ? w_eb : w_ea)});
            r_sig_big <= w_swap ? w_sigb : w_siga;
            r_sig_sml <= w_swap ? w_siga : w_sigb;
            r_shift   <= w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
            r_err     <= w_a_nan | w_b_nan | r_sel[1] | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
            r_inf     <= w_a_inf | w_b_inf;
            r_inf_sgn <= w_a_inf ? w_sa : w_sb;
         end
         S_ALIGN: r_aln <= w_aln;
         S_ADD:   r_sum <= w_sum;
         S_NORM: begin
            r_norm <= w_norm;
            r_nexp <= w_nexp;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_ovf   <= 1'b0;
         r_y     <= '0;
      end else begin
         r_done <= (r_state == S_ROUND);
         if (r_state == S_ROUND) begin
            r_y     <= w_res;
            r_error <= r_err;
            r_ovf   <= !r_err && !r_inf && r_norm[EXT_W-1] && !w_uf && w_of;
         end
      end
   end

   assign o_done     = r_done;
   assign o_error    = r_error;
   assign o_overflow = r_ovf;
   assign o_y        = r_y;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: hand-computed single-precision vectors, latency,
// start handling while busy or in the done cycle, and asynchronous reset behaviour.
module tb_fp_addsub_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] i_a = '0, i_b = '0;
   logic [1:0]  i_sel = '0, i_round = '0;
   logic        i_start = 1'b0;
   logic        o_busy, o_done, o_error, o_overflow;
   logic [31:0] o_y;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          nd;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(i_a), .i_b(i_b), .i_sel(i_sel),
      .i_round(i_round), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
      .o_error(o_error), .o_overflow(o_overflow), .o_y(o_y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic count_done(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (o_done === 1'b1) c++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sel, input logic [1:0] rnd,
                         input logic [31:0] ey, input logic eerr, input logic eovf);
      int lat;
      @(negedge clk);
      i_a = a; i_b = b; i_sel = sel; i_round = rnd; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_a = ~a; i_b = ~b; i_sel = ~sel; i_round = ~rnd;
      chk({tag, ".busy"}, {31'd0, o_busy}, 32'd1);
      lat = 1;
      while (o_done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"}, lat, 32'd6);
      chk({tag, ".y"}, o_y, ey);
      chk({tag, ".err"}, {31'd0, o_error}, {31'd0, eerr});
      chk({tag, ".ovf"}, {31'd0, o_overflow}, {31'd0, eovf});
      @(posedge clk); #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst.y", o_y, 32'h0);
      chk("rst.busy", {31'd0, o_busy}, 32'd0);
      chk("rst.done", {31'd0, o_done}, 32'd0);
      chk("rst.err", {31'd0, o_error}, 32'd0);
      chk("rst.ovf", {31'd0, o_overflow}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      run_op("add15_28",  32'h41700000, 32'h41E00000, 2'b00, 2'b00, 32'h422C0000, 1'b0, 1'b0);
      run_op("sub15_28",  32'h41700000, 32'h41E00000, 2'b01, 2'b00, 32'hC1500000, 1'b0, 1'b0);
      run_op("1m1_rne",   32'h3F800000, 32'h3F800000, 2'b01, 2'b00, 32'h00000000, 1'b0, 1'b0);
      run_op("1m1_rmi",   32'h3F800000, 32'h3F800000, 2'b01, 2'b11, 32'h80000000, 1'b0, 1'b0);
      run_op("tie_rne",   32'h3F800000, 32'h33800000, 2'b00, 2'b00, 32'h3F800000, 1'b0, 1'b0);
      run_op("tie_rpi",   32'h3F800000, 32'h33800000, 2'b00, 2'b10, 32'h3F800001, 1'b0, 1'b0);
      run_op("tie_rmi",   32'h3F800000, 32'h33800000, 2'b00, 2'b11, 32'h3F800000, 1'b0, 1'b0);
      run_op("ovf_rne",   32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 2'b00, 32'h7F800000, 1'b0, 1'b1);
      run_op("ovf_rz",    32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 2'b01, 32'h7F7FFFFF, 1'b0, 1'b1);
      run_op("novf_rpi",  32'hFF7FFFFF, 32'hFF7FFFFF, 2'b00, 2'b10, 32'hFF7FFFFF, 1'b0, 1'b1);
      run_op("novf_rmi",  32'hFF7FFFFF, 32'hFF7FFFFF, 2'b00, 2'b11, 32'hFF800000, 1'b0, 1'b1);
      run_op("one_m_ulp", 32'h3F800000, 32'h33800000, 2'b01, 2'b00, 32'h3F7FFFFF, 1'b0, 1'b0);
      run_op("1p5_2p5",   32'h3FC00000, 32'h40200000, 2'b00, 2'b00, 32'h40800000, 1'b0, 1'b0);
      run_op("nz_nz",     32'h80000000, 32'h80000000, 2'b00, 2'b00, 32'h80000000, 1'b0, 1'b0);
      run_op("denorm_in", 32'h00000001, 32'h3F800000, 2'b00, 2'b00, 32'h3F800000, 1'b0, 1'b0);
      run_op("underflow", 32'h00800000, 32'h00C00000, 2'b01, 2'b00, 32'h80000000, 1'b0, 1'b0);
      run_op("inf_p1",    32'h7F800000, 32'h3F800000, 2'b00, 2'b00, 32'h7F800000, 1'b0, 1'b0);
      run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 2'b01, 2'b00, 32'h7FC00000, 1'b1, 1'b0);
      run_op("sel_rsv",   32'h3F800000, 32'h3F800000, 2'b10, 2'b00, 32'h7FC00000, 1'b1, 1'b0);
      run_op("nan_in",    32'h7FC00000, 32'h3F800000, 2'b00, 2'b00, 32'h7FC00000, 1'b1, 1'b0);

      // reset while the operation sits in ALIGN
      @(negedge clk);
      i_a = 32'h41700000; i_b = 32'h41E00000; i_sel = 2'b00; i_round = 2'b00; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("midrst.y", o_y, 32'h0);
      chk("midrst.err", {31'd0, o_error}, 32'd0);
      chk("midrst.busy", {31'd0, o_busy}, 32'd0);
      chk("midrst.done", {31'd0, o_done}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      count_done(12, nd);
      chk("midrst.nodone", nd, 32'd0);
      run_op("after_rst", 32'h41700000, 32'h41E00000, 2'b00, 2'b00, 32'h422C0000, 1'b0, 1'b0);

      // start pulses while busy yield a single completion
      @(negedge clk);
      i_a = 32'h3FC00000; i_b = 32'h40200000; i_sel = 2'b00; i_round = 2'b00; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      @(negedge clk) i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
      count_done(15, nd);
      chk("busy_start.ndone", nd, 32'd1);
      chk("busy_start.y", o_y, 32'h40800000);

      // start raised during the done cycle is not accepted
      @(negedge clk);
      i_a = 32'h41700000; i_b = 32'h41E00000; i_sel = 2'b01; i_round = 2'b00; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      nd = 0;
      while (o_done !== 1'b1 && nd < 20) begin
         @(posedge clk); #1;
         nd++;
      end
      chk("done_start.seen", {31'd0, o_done}, 32'd1);
      i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      chk("done_start.busy", {31'd0, o_busy}, 32'd0);
      count_done(10, nd);
      chk("done_start.ndone", nd, 32'd0);
      chk("done_start.hold", o_y, 32'hC1500000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
